// File: rtl/sram_controller.sv
// Request/response front-end for a single-port asynchronous-read SRAM.
// One access in flight; strobes and bus enable are registered and held for WAIT_CYCLES+1 cycles.
module sram_controller #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic                  sram_oe_o,
  inout  wire  [DATA_WIDTH-1:0] sram_data_io
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;

  // The bus is driven only while the write strobe is up, so it never fights the SRAM.
  assign sram_data_io = sram_we_o ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_we_o    <= 1'b0;
      rsp_rdata_o <= '0;
      sram_addr_o <= '0;
      sram_ce_o   <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_oe_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            wdata_q     <= req_wdata_i;
            sram_addr_o <= req_addr_i;
            wait_cnt    <= CNT_W'(WAIT_CYCLES);
            req_ready_o <= 1'b0;
            sram_ce_o   <= 1'b1;
            sram_we_o   <= req_we_i;
            sram_oe_o   <= ~req_we_i;
            state       <= req_we_i ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          // Last access edge: drop strobes, capture read data, raise the response.
          if (wait_cnt == '0) begin
            sram_ce_o   <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_oe_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= we_q;
            if (state == READ) begin
              rsp_rdata_o <= sram_data_io;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller with a behavioural SRAM and reference memory.
module tb_sram_controller;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned W  = 3;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_ce, sram_we, sram_oe;
  tri1  [DW-1:0] sram_data;

  sram_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .sram_addr_o(sram_addr), .sram_ce_o(sram_ce), .sram_we_o(sram_we),
    .sram_oe_o(sram_oe), .sram_data_io(sram_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read when ce&oe&!we, write on clock edges with ce&we.
  logic [DW-1:0] mem [DEPTH];
  assign sram_data = (sram_ce && sram_oe && !sram_we) ? mem[sram_addr] : {DW{1'bz}};
  always @(posedge clk) if (sram_ce && sram_we) mem[sram_addr] <= sram_data;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rd;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_acc = -1;
  int            ce_run = 0;
  int            rdy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor: pops the scoreboard whenever a response pulse is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd = '0;
    end else if (rsp_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("rsp_we", 32'(rsp_we), 32'(mon_e.we));
        check("rsp_latency", 32'(cyc - mon_e.acc), 32'(W + 1));
        if (!mon_e.we) last_rd = mon_e.data;
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
      end
    end
  end

  // Bus/strobe protocol monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      ce_run  = 0;
      rdy_run = 0;
    end else begin
      check("we_oe_exclusive", 32'(sram_we && sram_oe), 32'(0));
      check("strobe_without_ce", 32'((sram_we || sram_oe) && !sram_ce), 32'(0));
      if (sram_ce) begin
        check("bus_known_ce", 32'($isunknown(sram_data)), 32'(0));
        ce_run++;
      end else begin
        check("bus_released", 32'(sram_data), 32'({DW{1'b1}}));
        if (ce_run > 0) check("strobe_len", 32'(ce_run), 32'(W + 1));
        ce_run = 0;
      end
      if (!req_ready) begin
        rdy_run++;
      end else begin
        if (rdy_run > 0) check("ready_low_len", 32'(rdy_run), 32'(W + 2));
        rdy_run = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit expect_rsp, input bit b2b);
    int   n = 0;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected accept", n);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    e.we  = we;
    if (we) begin
      ref_mem[a] = d;
      e.data = d;
    end else begin
      e.data = ref_mem[a];
    end
    if (b2b && last_acc >= 0) check("accept_spacing", 32'(e.acc - last_acc), 32'(W + 3));
    last_acc = e.acc;
    if (expect_rsp) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields while the controller is busy.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'(1));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_strobes"}, 32'({sram_ce, sram_we, sram_oe}), 32'(0));
    check({tag, "_bus_z"}, 32'(sram_data), 32'({DW{1'b1}}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          we;
    logic [AW-1:0] a;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check_reset_state("por");
    check("por_rsp_we", 32'(rsp_we), 32'(0));
    check("por_rdata", 32'(rsp_rdata), 32'(0));
    check("por_addr", 32'(sram_addr), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back.
    issue(1'b1, 8'h10, 16'hA5A5, 1'b1, 1'b0);
    issue(1'b0, 8'h10, 16'h0000, 1'b1, 1'b0);
    drain();

    // Single read: strobe length and ready-low length checked by the monitor.
    issue(1'b0, 8'h44, 16'h0000, 1'b1, 1'b0);
    drain();

    // Full sweep with valid held high between requests.
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, AW'(i), DW'(i) ^ 16'h5A5A, 1'b1, i != 0);
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, AW'(i), 16'h0000, 1'b1, i != 0);
    drain();

    // Reset in the middle of a read discards it; memory survives.
    issue(1'b1, 8'h20, 16'h1234, 1'b1, 1'b0);
    drain();
    issue(1'b0, 8'h30, 16'h0000, 1'b0, 1'b0);
    check("mid_read_ce", 32'(sram_ce), 32'(1));
    #1 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    repeat (2) @(negedge clk);
    check("rst_no_rsp", 32'(rsp_valid), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'h20, 16'h0000, 1'b1, 1'b0);
    drain();

    // Random mix over a small address window with idle gaps.
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we = 1'($urandom);
      a  = AW'($urandom_range(0, 15));
      issue(we, a, DW'($urandom), 1'b1, 1'b0);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
